// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with selectable standard or first-word-fall-through read,
// occupancy count, almost flags, and sticky error flags when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_flex #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    r_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                    overflow,
  output logic                    underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LEVEL   = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LEVEL   = PW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [PW-1:0]         r_count;
  logic                  w_wrAccept;
  logic                  w_rdAccept;

  // Pointers carry one extra bit so equal pointers unambiguously mean empty.
  assign empty        = (r_wrPtr == r_rdPtr);
  assign full         = (r_count == FULL_COUNT);
  assign almost_full  = (r_count >= AF_LEVEL);
  assign almost_empty = (r_count <= AE_LEVEL);
  assign count        = r_count;

  assign w_wrAccept = w_en & ~full;
  assign w_rdAccept = r_en & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrAccept) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_rdAccept) r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_wrAccept, w_rdAccept})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (rst_n && w_wrAccept) r_mem[r_wrPtr[AW-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dataOut;

      always_ff @(posedge clk) begin
        if (!rst_n)          r_dataOut <= '0;
        else if (w_rdAccept) r_dataOut <= r_mem[r_rdPtr[AW-1:0]];
      end

      assign data_out = r_dataOut;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Flags latch any rejected request and hold until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_en && full)  r_overflow  <= 1'b1;
      if (r_en && empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed self-checking bench for sync_fifo_flex: one standard-read instance
// and one FWFT instance share clock and reset.
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rst_n;
  int         errors = 0;
  int         checks = 0;

  logic       w_en0, r_en0;
  logic [7:0] din0, dout0;
  logic       full0, empty0, af0, ae0;
  logic [3:0] count0;

  logic       w_en1, r_en1;
  logic [7:0] din1, dout1;
  logic       full1, empty1, af1, ae1;
  logic [3:0] count1;

`ifdef SYNC_FIFO_ERR_EN
  logic       ovf0, unf0, ovf1, unf1;
`endif

  always #5 clk = ~clk;

  sync_fifo_flex #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_std (
    .clk(clk), .rst_n(rst_n), .w_en(w_en0), .data_in(din0), .r_en(r_en0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0)
`ifdef SYNC_FIFO_ERR_EN
    , .overflow(ovf0), .underflow(unf0)
`endif
  );

  sync_fifo_flex #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .w_en(w_en1), .data_in(din1), .r_en(r_en1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1)
`ifdef SYNC_FIFO_ERR_EN
    , .overflow(ovf1), .underflow(unf1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_en0 = 1'b1; r_en0 = 1'b1; din0 = 8'h55;
    w_en1 = 1'b1; r_en1 = 1'b1; din1 = 8'h55;
    tick();
    tick();
    rst_n = 1'b1; w_en0 = 1'b0; r_en0 = 1'b0; w_en1 = 1'b0; r_en1 = 1'b0;
    checks++; if (count0 !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", count0); end
    checks++; if ({full0, empty0, af0, ae0} !== 4'b0101) begin errors++; $display("[TB] FAIL reset_flags got=%b exp=0101", {full0, empty0, af0, ae0}); end
    checks++; if (dout0 !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout got=%h exp=00", dout0); end
    checks++; if (dout1 !== 8'h00 || empty1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_fwft got dout=%h empty=%b exp 00/1", dout1, empty1); end
`ifdef SYNC_FIFO_ERR_EN
    checks++; if ({ovf0, unf0} !== 2'b00) begin errors++; $display("[TB] FAIL reset_err got=%b exp=00", {ovf0, unf0}); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      w_en0 = 1'b1; din0 = 8'(i);
      tick();
      checks++; if (count0 !== 4'(i)) begin errors++; $display("[TB] FAIL fill_count[%0d] got=%0d exp=%0d", i, count0, i); end
      checks++; if (ae0 !== (i <= 2)) begin errors++; $display("[TB] FAIL fill_ae[%0d] got=%b exp=%b", i, ae0, (i <= 2)); end
      checks++; if (af0 !== (i >= 6)) begin errors++; $display("[TB] FAIL fill_af[%0d] got=%b exp=%b", i, af0, (i >= 6)); end
      checks++; if (full0 !== (i == 8) || empty0 !== 1'b0) begin errors++; $display("[TB] FAIL fill_fullempty[%0d] got=%b%b exp=%b0", i, full0, empty0, (i == 8)); end
    end
    din0 = 8'hFF;
    tick();
    w_en0 = 1'b0;
    checks++; if (count0 !== 4'd8 || full0 !== 1'b1) begin errors++; $display("[TB] FAIL overfill_count got=%0d full=%b exp=8/1", count0, full0); end
`ifdef SYNC_FIFO_ERR_EN
    checks++; if (ovf0 !== 1'b1 || unf0 !== 1'b0) begin errors++; $display("[TB] FAIL overflow_set got ovf=%b unf=%b exp 1/0", ovf0, unf0); end
`endif
  endtask

  task automatic test_read_std();
    for (int i = 1; i <= 8; i++) begin
      r_en0 = 1'b1;
      tick();
      checks++; if (dout0 !== 8'(i)) begin errors++; $display("[TB] FAIL read_data[%0d] got=%h exp=%h", i, dout0, 8'(i)); end
      checks++; if (count0 !== 4'(8 - i)) begin errors++; $display("[TB] FAIL read_count[%0d] got=%0d exp=%0d", i, count0, 8 - i); end
    end
    checks++; if (empty0 !== 1'b1 || ae0 !== 1'b1 || af0 !== 1'b0) begin errors++; $display("[TB] FAIL drained_flags got e=%b ae=%b af=%b exp 1/1/0", empty0, ae0, af0); end
    tick();
    r_en0 = 1'b0;
    checks++; if (dout0 !== 8'h08 || count0 !== 4'd0) begin errors++; $display("[TB] FAIL underread got dout=%h count=%0d exp 08/0", dout0, count0); end
`ifdef SYNC_FIFO_ERR_EN
    checks++; if (unf0 !== 1'b1) begin errors++; $display("[TB] FAIL underflow_set got=%b exp=1", unf0); end
`endif
  endtask

  task automatic test_fwft();
    w_en1 = 1'b1; din1 = 8'hA5;
    tick();
    w_en1 = 1'b0;
    checks++; if (dout1 !== 8'hA5) begin errors++; $display("[TB] FAIL fwft_show got=%h exp=a5", dout1); end
    tick();
    checks++; if (dout1 !== 8'hA5 || count1 !== 4'd1) begin errors++; $display("[TB] FAIL fwft_hold got=%h count=%0d exp a5/1", dout1, count1); end
    r_en1 = 1'b1;
    tick();
    r_en1 = 1'b0;
    checks++; if (empty1 !== 1'b1 || dout1 !== 8'h00) begin errors++; $display("[TB] FAIL fwft_pop got empty=%b dout=%h exp 1/00", empty1, dout1); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      w_en0 = 1'b1; din0 = 8'h10 + 8'(i);
      tick();
    end
    checks++; if (count0 !== 4'd4) begin errors++; $display("[TB] FAIL b2b_prefill got=%0d exp=4", count0); end
    for (int k = 0; k < 10; k++) begin
      w_en0 = 1'b1; r_en0 = 1'b1; din0 = 8'h14 + 8'(k);
      tick();
      checks++; if (count0 !== 4'd4 || dout0 !== 8'h10 + 8'(k)) begin errors++; $display("[TB] FAIL b2b[%0d] got count=%0d dout=%h exp 4/%h", k, count0, dout0, 8'h10 + 8'(k)); end
    end
    w_en0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (dout0 !== 8'h1A + 8'(k)) begin errors++; $display("[TB] FAIL b2b_drain[%0d] got=%h exp=%h", k, dout0, 8'h1A + 8'(k)); end
    end
    r_en0 = 1'b0;
    checks++; if (empty0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty got=%b exp=1", empty0); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 8; i++) begin
      w_en0 = 1'b1; din0 = 8'h20 + 8'(i);
      tick();
    end
    w_en0 = 1'b1; r_en0 = 1'b1; din0 = 8'hEE;
    tick();
    w_en0 = 1'b0;
    checks++; if (count0 !== 4'd7 || full0 !== 1'b0 || dout0 !== 8'h20) begin errors++; $display("[TB] FAIL full_simul got count=%0d full=%b dout=%h exp 7/0/20", count0, full0, dout0); end
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++; if (dout0 !== 8'h20 + 8'(i)) begin errors++; $display("[TB] FAIL full_simul_read[%0d] got=%h exp=%h", i, dout0, 8'h20 + 8'(i)); end
    end
    r_en0 = 1'b0;
    checks++; if (empty0 !== 1'b1 || count0 !== 4'd0) begin errors++; $display("[TB] FAIL full_simul_dropped got empty=%b count=%0d exp 1/0", empty0, count0); end
  endtask

  task automatic test_empty_simul();
    w_en0 = 1'b1; r_en0 = 1'b1; din0 = 8'h33;
    tick();
    w_en0 = 1'b0;
    checks++; if (count0 !== 4'd1 || dout0 !== 8'h27) begin errors++; $display("[TB] FAIL empty_simul got count=%0d dout=%h exp 1/27", count0, dout0); end
    tick();
    r_en0 = 1'b0;
    checks++; if (dout0 !== 8'h33 || empty0 !== 1'b1) begin errors++; $display("[TB] FAIL empty_simul_read got dout=%h empty=%b exp 33/1", dout0, empty0); end
  endtask

  task automatic test_err_and_reset();
`ifdef SYNC_FIFO_ERR_EN
    checks++; if ({ovf0, unf0} !== 2'b11) begin errors++; $display("[TB] FAIL err_sticky got=%b exp=11", {ovf0, unf0}); end
`endif
    for (int i = 0; i < 3; i++) begin
      w_en0 = 1'b1; din0 = 8'h40 + 8'(i);
      tick();
    end
    r_en0 = 1'b1; w_en0 = 1'b0;
    tick();
    checks++; if (dout0 !== 8'h40 || count0 !== 4'd2) begin errors++; $display("[TB] FAIL midstream got dout=%h count=%0d exp 40/2", dout0, count0); end
    rst_n = 1'b0; w_en0 = 1'b1; r_en0 = 1'b1; din0 = 8'h77;
    tick();
    rst_n = 1'b1; w_en0 = 1'b0; r_en0 = 1'b0;
    checks++; if (count0 !== 4'd0 || dout0 !== 8'h00 || empty0 !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset got count=%0d dout=%h empty=%b exp 0/00/1", count0, dout0, empty0); end
`ifdef SYNC_FIFO_ERR_EN
    checks++; if ({ovf0, unf0} !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_err got=%b exp=00", {ovf0, unf0}); end
    r_en0 = 1'b1;
    tick();
    r_en0 = 1'b0;
    checks++; if ({ovf0, unf0} !== 2'b01) begin errors++; $display("[TB] FAIL underflow_only got=%b exp=01", {ovf0, unf0}); end
    for (int i = 0; i < 9; i++) begin
      w_en0 = 1'b1; din0 = 8'(i);
      tick();
    end
    w_en0 = 1'b0;
    tick();
    checks++; if ({ovf0, unf0} !== 2'b11 || count0 !== 4'd8) begin errors++; $display("[TB] FAIL overflow_again got=%b count=%0d exp 11/8", {ovf0, unf0}, count0); end
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    w_en0 = 1'b0; r_en0 = 1'b0; din0 = 8'h00;
    w_en1 = 1'b0; r_en1 = 1'b0; din1 = 8'h00;
    test_reset();
    test_fill();
    test_read_std();
    test_fwft();
    test_back_to_back();
    test_full_simul();
    test_empty_simul();
    test_err_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
